// File: rtl/scm_ctrl_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package scm_ctrl_pkg;

  localparam int SCM_ADDR_WIDTH = 5;
  localparam int SCM_DATA_WIDTH = 32;

  // Write request as carried for the default register file geometry.
  typedef struct packed {
    logic [SCM_ADDR_WIDTH-1:0]   addr;
    logic [SCM_DATA_WIDTH-1:0]   wdata;
    logic [SCM_DATA_WIDTH/8-1:0] be;
  } wr_req_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/scm_rr_arbiter.sv
// Generic N-input round-robin arbiter with per-requester lock (priority hold).
module scm_rr_arbiter
  import scm_ctrl_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     valid,
  input  logic [N-1:0]     lock,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] rr_q;

  // First valid requester at or after the pointer wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && valid[(int'(rr_q) + k) % N]) begin
        gnt_any                       = 1'b1;
        gnt[(int'(rr_q) + k) % N]     = 1'b1;
        gnt_idx                       = IDX_W'((int'(rr_q) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_q <= '0;
    else if (gnt_any)
      rr_q <= lock[gnt_idx] ? gnt_idx : IDX_W'(rr_next(int'(gnt_idx), N));
  end

endmodule

// File: rtl/scm_write_arbiter.sv
// Round-robin write-port arbiter with registered issue, read-during-write
// hazard flags and an issued-write counter for the latch-based register file.
module scm_write_arbiter
  import scm_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8,
  parameter int N_REQ      = 4,
  parameter int N_READ     = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  input  logic [N_REQ-1:0]                      req_lock_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_wdata_i,
  input  logic [N_REQ-1:0][NUM_BYTE-1:0]        req_be_i,
  output logic                                  WriteEnable,
  output logic [ADDR_WIDTH-1:0]                 WriteAddr,
  output logic [DATA_WIDTH-1:0]                 WriteData,
  output logic [NUM_BYTE-1:0]                   WriteBE,
  input  logic [N_READ-1:0]                     ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]     ReadAddr,
  output logic [N_READ-1:0]                     rd_hazard_o,
  input  logic                                  cnt_clear_i,
  output logic [CNT_WIDTH-1:0]                  wr_count_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [N_REQ-1:0] arb_valid;

  // No grants while in reset so nothing is consumed and then dropped.
  assign arb_valid = req_valid_i & {N_REQ{~rst}};

  scm_rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (arb_valid),
    .lock    (req_lock_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready_o = gnt;

  // Flopped issue so the register file sees glitch-free write controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      WriteEnable <= 1'b0;
      WriteAddr   <= '0;
      WriteData   <= '0;
      WriteBE     <= '0;
    end else if (gnt_any) begin
      WriteEnable <= |req_be_i[gnt_idx];
      WriteAddr   <= req_addr_i[gnt_idx];
      WriteData   <= req_wdata_i[gnt_idx];
      WriteBE     <= req_be_i[gnt_idx];
    end else begin
      WriteEnable <= 1'b0;
    end
  end

  for (genvar z = 0; z < N_READ; z++) begin : g_hz
    assign rd_hazard_o[z] = ~rst & ReadEnable[z] & WriteEnable &
                            (ReadAddr[z] == WriteAddr);
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear_i)
      wr_count_o <= '0;
    else if (WriteEnable)
      wr_count_o <= wr_count_o + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_scm_write_arbiter.sv
// Scoreboard bench for scm_write_arbiter: directed scenarios plus random traffic.
module tb_scm_write_arbiter;
  localparam int AW = 5, DW = 32, NB = 4, NR = 4, NRD = 2, CW = 4;

  logic clk = 1'b0;
  logic rst, clr;
  logic [NR-1:0] req_valid, req_ready, req_lock;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_wdata;
  logic [NR-1:0][NB-1:0] req_be;
  logic we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NB-1:0] wbe;
  logic [NRD-1:0] ren, hz;
  logic [NRD-1:0][AW-1:0] raddr;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  scm_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .N_REQ(NR),
                      .N_READ(NRD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_lock_i(req_lock),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .WriteEnable(we), .WriteAddr(waddr), .WriteData(wdata), .WriteBE(wbe),
    .ReadEnable(ren), .ReadAddr(raddr), .rd_hazard_o(hz),
    .cnt_clear_i(clr), .wr_count_o(cnt)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NB-1:0] be;
    logic [CW-1:0] c;
  } iss_t;

  iss_t           iss_q[$];
  int             gnt_q[$];
  int             obs_q[$];
  logic [NRD-1:0] hz_q[$];
  int vec = 0, mis = 0;

  // Reference state: what the spec says the block holds after each edge.
  int            m_rr = 0, last_g = -1;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [CW-1:0] m_cnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_seq(input string nm, input int exp[8], input int n);
    vec++;
    if (obs_q.size() != n) begin
      mis++;
      $display("FAIL %s: got %0d grants want %0d", nm, obs_q.size(), n);
    end else
      for (int i = 0; i < n; i++)
        if (obs_q[i] != exp[i]) begin
          mis++;
          $display("FAIL %s[%0d]: got %0d want %0d", nm, i, obs_q[i], exp[i]);
          break;
        end
  endtask

  // Evaluate the spec model on the current inputs, queue expectations, advance one cycle.
  task automatic tick();
    int g;
    logic [NRD-1:0] eh;
    #1;
    for (int z = 0; z < NRD; z++)
      eh[z] = !rst && ren[z] && m_we && (raddr[z] == m_addr);
    hz_q.push_back(eh);
    g = -1;
    if (!rst)
      for (int k = 0; k < NR; k++)
        if (g < 0 && req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
    gnt_q.push_back(g);
    if (rst) begin
      m_rr = 0; m_we = 1'b0; m_addr = '0; m_cnt = '0;
    end else begin
      if (clr) m_cnt = '0;
      if (g >= 0) begin
        m_rr   = req_lock[g] ? g : (g + 1) % NR;
        m_addr = req_addr[g];
        m_we   = |req_be[g];
        if (m_we) begin
          iss_q.push_back('{req_addr[g], req_wdata[g], req_be[g], m_cnt});
          m_cnt = m_cnt + 1'b1;
        end
      end else
        m_we = 1'b0;
    end
    last_g = g;
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; clr = 1'b0; req_valid = '0; req_lock = '0; ren = '0;
  endtask

  task automatic one_write(input int r, input logic [AW-1:0] a, input logic [NB-1:0] be);
    idle();
    req_valid[r] = 1'b1; req_addr[r] = a; req_wdata[r] = $urandom; req_be[r] = be;
  endtask

  // Grant / hazard monitor: the block presents both every cycle.
  always @(negedge clk) begin
    int g, e;
    logic [NRD-1:0] eh;
    #3;
    if (gnt_q.size() > 0) begin
      g = -1;
      if ($countones(req_ready) > 1) g = -2;
      else for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
      if (g >= 0) obs_q.push_back(g);
      e = gnt_q.pop_front();
      vec++;
      if (g != e) begin mis++; $display("FAIL grant: got %0d want %0d (ready=%b)", g, e, req_ready); end
    end
    if (hz_q.size() > 0) begin
      eh = hz_q.pop_front();
      vec++;
      if (hz !== eh) begin mis++; $display("FAIL hazard: got %b want %b", hz, eh); end
    end
  end

  // Issue monitor: pops one expected write per cycle the register file is written.
  always @(posedge clk) begin
    iss_t e;
    #1;
    if (we === 1'b1) begin
      vec++;
      if (iss_q.size() == 0) begin
        mis++; $display("FAIL issue: unexpected write addr=%0d be=%b", waddr, wbe);
      end else begin
        e = iss_q.pop_front();
        if ({waddr, wdata, wbe, cnt} !== {e.a, e.d, e.be, e.c}) begin
          mis++;
          $display("FAIL issue: got a=%0d d=%h be=%b cnt=%0d want a=%0d d=%h be=%b cnt=%0d",
                   waddr, wdata, wbe, cnt, e.a, e.d, e.be, e.c);
        end
      end
    end
  end

  initial begin
    int rr_exp[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int lk_exp[8]  = '{1, 2, 2, 2, 2, 3, 1, 0};
    int zb_exp[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    idle(); rst = 1'b1;
    req_addr = '0; req_wdata = '0; req_be = '0; raddr = '0;
    @(negedge clk);

    // Reset held with all requesters valid.
    req_valid = '1;
    for (int i = 0; i < NR; i++) begin req_addr[i] = AW'(i + 1); req_be[i] = '1; end
    tick(); tick();
    #1;
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_we", 64'(we), 64'h0);
    chk("reset_cnt", 64'(cnt), 64'h0);
    tick();

    // Round robin, no lock.
    rst = 1'b0; obs_q.delete();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NR; i++) begin
        req_addr[i] = AW'($urandom); req_wdata[i] = $urandom; req_be[i] = NB'($urandom) | 1'b1;
      end
      tick();
    end
    idle(); tick(); tick();
    chk_seq("rr_order", rr_exp, 8);
    #1 chk("rr_count", 64'(cnt), 64'd8);

    // Lock burst on requester 2, then release.
    obs_q.delete();
    one_write(1, 5'd9, 4'hf); tick();
    req_valid = 4'b1110; req_lock = 4'b0100;
    for (int i = 1; i < NR; i++) begin req_addr[i] = AW'(10 + i); req_be[i] = 4'h3; end
    tick(); tick(); tick();
    req_lock = '0;
    tick(); tick(); tick();
    idle(); tick(); tick();
    chk_seq("lock_burst", lk_exp, 7);

    // Zero byte-enable request is consumed but not issued.
    clr = 1'b1; tick();
    obs_q.delete();
    one_write(0, 5'd5, 4'h0); tick();
    idle();
    #1 chk("zero_be_we", 64'(we), 64'h0);
    tick();
    chk_seq("zero_be_ready", zb_exp, 1);
    #1 chk("zero_be_cnt", 64'(cnt), 64'h0);

    // Read-during-write hazard.
    one_write(0, 5'd7, 4'hf); tick();
    idle(); ren = 2'b11; raddr[0] = 5'd7; raddr[1] = 5'd3;
    #1 chk("hazard_hit", 64'(hz), 64'h1);
    tick();
    #1 chk("hazard_idle", 64'(hz), 64'h0);
    tick();

    // Counter wrap and clear-vs-increment priority.
    idle(); clr = 1'b1; tick();
    for (int c = 0; c < 15; c++) begin one_write(0, AW'(c), 4'h1); tick(); end
    idle(); tick(); tick();
    #1 chk("cnt_full", 64'(cnt), 64'd15);
    one_write(2, 5'd1, 4'h8); tick();
    idle(); tick(); tick();
    #1 chk("cnt_wrap", 64'(cnt), 64'h0);
    one_write(3, 5'd2, 4'h2); tick();
    idle(); clr = 1'b1; tick();
    clr = 1'b0;
    #1 chk("cnt_clear_prio", 64'(cnt), 64'h0);
    tick();

    // Random traffic; pending requests stay stable unless dropped.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom % 200) == 0;
      clr = ($urandom % 32) == 0;
      for (int i = 0; i < NR; i++)
        if (!(req_valid[i] && last_g != i && ($urandom % 8) != 0)) begin
          req_valid[i] = ($urandom % 10) < 6;
          req_lock[i]  = ($urandom % 6) == 0;
          req_addr[i]  = AW'($urandom % 8);
          req_wdata[i] = $urandom;
          req_be[i]    = (($urandom % 6) == 0) ? '0 : NB'($urandom);
        end
      for (int z = 0; z < NRD; z++) begin
        ren[z] = 1'($urandom);
        raddr[z] = AW'($urandom % 8);
      end
      tick();
    end

    idle(); tick(); tick(); tick();
    #4;
    chk("final_cnt", 64'(cnt), 64'(m_cnt));
    chk("iss_q_drained", 64'(iss_q.size()), 64'h0);
    chk("gnt_q_drained", 64'(gnt_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
